// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - serial frame transmitter: start bit, LSB-first data, optional even parity (SERIAL_TX_PARITY_EN), two stop bits
module serial_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              sout,
  output logic              busy,
  output logic              frame_done
);

  // Counter widths hold their own maximum value, never narrower than one bit.
  // bit_cnt must reach DATA_W-1 for data and 1 for the stop trailer.
  localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BIT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
`ifdef SERIAL_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [CYC_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              sout_q, sout_d;
  logic              done_q, done_d;
  logic              bit_end;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  // Next-state logic; sout is derived from the next state so the line is registered
  always_comb begin
    state_d   = state_q;
    cyc_cnt_d = cyc_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    sout_d    = 1'b0;
    bit_end   = (cyc_cnt_q == CYC_LAST);
`ifdef SERIAL_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          state_d   = S_START;
          shift_d   = tx_data;
          cyc_cnt_d = '0;
          bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
          parity_d  = ^tx_data;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          cyc_cnt_d = '0;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cyc_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d   = S_STOP;
          cyc_cnt_d = '0;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          cyc_cnt_d = '0;
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            state_d   = S_IDLE;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cyc_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase

    case (state_d)
      S_START:  sout_d = 1'b1;
      S_DATA:   sout_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: sout_d = parity_d;
`endif
      default:  sout_d = 1'b0;
    endcase
  end

  // State, counters, shift register and registered outputs; reset drops the line at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cyc_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sout_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cyc_cnt_q <= cyc_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sout_q    <= sout_d;
      done_q    <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign sout       = sout_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - self-checking bench for serial_frame_tx against a frame-level model
module tb_serial_frame_tx;

`ifdef SERIAL_TX_PARITY_EN
  localparam int FB = 12;
`else
  localparam int FB = 11;
`endif
  localparam int BC  = 4;
  localparam int LEN = FB * BC;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid, tx_valid1;
  logic [7:0] tx_data, tx_data1;
  logic       tx_ready, sout, busy, frame_done;
  logic       tx_ready1, sout1, busy1, frame_done1;

  int checks = 0;
  int errors = 0;

  // Outputs packed as {sout, busy, tx_ready, frame_done}
  localparam logic [3:0] IDLE_V = 4'b0010;
  localparam logic [3:0] DONE_V = 4'b0011;

  serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .sout(sout), .busy(busy), .frame_done(frame_done)
  );

  serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid1), .tx_data(tx_data1),
    .tx_ready(tx_ready1), .sout(sout1), .busy(busy1), .frame_done(frame_done1)
  );

  always #5 clk = ~clk;

  // Frame symbol k of a word: start 1, data LSB first, optional even parity, stop zeros
  function automatic logic exp_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b1;
    if (k <= 8) return d[k-1];
`ifdef SERIAL_TX_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b0;
  endfunction

  // Expected {sout,busy,ready,done} in cycle c (1-based after the handshake edge)
  function automatic logic [3:0] exp_vec(input logic [7:0] d, input int c, input int bc);
    if (c <= FB * bc) return {exp_bit(d, (c - 1) / bc), 1'b1, 1'b0, 1'b0};
    if (c == FB * bc + 1) return DONE_V;
    return IDLE_V;
  endfunction

  task automatic handshake(input logic [7:0] d);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic test_reset;
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF; tx_valid1 = 1'b1; tx_data1 = 8'hFF;
    #1;
    checks++;
    if ({sout, busy, tx_ready, frame_done} !== IDLE_V) begin
      errors++; $display("FAIL reset_state got %b exp %b", {sout, busy, tx_ready, frame_done}, IDLE_V);
    end
    checks++;
    if ({sout1, busy1, tx_ready1, frame_done1} !== IDLE_V) begin
      errors++; $display("FAIL reset_state_bc1 got %b exp %b", {sout1, busy1, tx_ready1, frame_done1}, IDLE_V);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sout, busy, tx_ready, frame_done} !== IDLE_V) begin
      errors++; $display("FAIL reset_valid_ignored got %b exp %b", {sout, busy, tx_ready, frame_done}, IDLE_V);
    end
    tx_valid = 1'b0; tx_valid1 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({sout, busy, tx_ready, frame_done} !== IDLE_V) begin
      errors++; $display("FAIL post_reset_idle got %b exp %b", {sout, busy, tx_ready, frame_done}, IDLE_V);
    end
  endtask

  task automatic test_frames;
    logic [7:0] d;
    for (int i = 0; i < 6; i++) begin
      d = (i == 0) ? 8'hA5 : (i == 1) ? 8'h01 : (i == 2) ? 8'h80 : 8'($urandom);
      handshake(d);
      for (int c = 1; c <= LEN + 1; c++) begin
        @(negedge clk);
        checks++;
        if ({sout, busy, tx_ready, frame_done} !== exp_vec(d, c, BC)) begin
          errors++;
          $display("FAIL frame d=%h cycle %0d got %b exp %b", d, c, {sout, busy, tx_ready, frame_done}, exp_vec(d, c, BC));
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] e;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    @(posedge clk);
    #1;
    tx_data = 8'h00;
    for (int c = 1; c <= 2 * LEN + 2; c++) begin
      @(negedge clk);
      if (c <= LEN + 1) e = exp_vec(8'hFF, c, BC);
      else              e = exp_vec(8'h00, c - LEN - 1, BC);
      checks++;
      if ({sout, busy, tx_ready, frame_done} !== e) begin
        errors++;
        $display("FAIL back_to_back cycle %0d got %b exp %b", c, {sout, busy, tx_ready, frame_done}, e);
      end
      if (c == LEN + 1) begin
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
      end
    end
  endtask

  task automatic test_busy_ignore;
    handshake(8'h3C);
    for (int c = 1; c <= LEN + 6; c++) begin
      @(negedge clk);
      checks++;
      if ({sout, busy, tx_ready, frame_done} !== exp_vec(8'h3C, c, BC)) begin
        errors++;
        $display("FAIL busy_ignore cycle %0d got %b exp %b", c, {sout, busy, tx_ready, frame_done}, exp_vec(8'h3C, c, BC));
      end
      if (c >= 2 && c <= 40) begin
        tx_valid = 1'($urandom);
        tx_data  = 8'($urandom);
      end else begin
        tx_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    handshake(8'hA5);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      checks++;
      if ({sout, busy, tx_ready, frame_done} !== exp_vec(8'hA5, c, BC)) begin
        errors++;
        $display("FAIL pre_reset cycle %0d got %b exp %b", c, {sout, busy, tx_ready, frame_done}, exp_vec(8'hA5, c, BC));
      end
    end
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'hC3;
    #1;
    checks++;
    if ({sout, busy, tx_ready, frame_done} !== IDLE_V) begin
      errors++; $display("FAIL reset_mid_async got %b exp %b", {sout, busy, tx_ready, frame_done}, IDLE_V);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; tx_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if ({sout, busy, tx_ready, frame_done} !== IDLE_V) begin
        errors++; $display("FAIL reset_mid_release step %0d got %b exp %b", c, {sout, busy, tx_ready, frame_done}, IDLE_V);
      end
    end
    handshake(8'h5A);
    for (int c = 1; c <= LEN + 1; c++) begin
      @(negedge clk);
      checks++;
      if ({sout, busy, tx_ready, frame_done} !== exp_vec(8'h5A, c, BC)) begin
        errors++;
        $display("FAIL after_reset cycle %0d got %b exp %b", c, {sout, busy, tx_ready, frame_done}, exp_vec(8'h5A, c, BC));
      end
    end
  endtask

  task automatic test_bit_cycles_1;
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? 8'h80 : 8'($urandom);
      @(negedge clk);
      tx_valid1 = 1'b1;
      tx_data1  = d;
      @(posedge clk);
      #1;
      tx_valid1 = 1'b0;
      tx_data1  = 8'($urandom);
      for (int c = 1; c <= FB + 2; c++) begin
        @(negedge clk);
        checks++;
        if ({sout1, busy1, tx_ready1, frame_done1} !== exp_vec(d, c, 1)) begin
          errors++;
          $display("FAIL bc1 d=%h cycle %0d got %b exp %b", d, c, {sout1, busy1, tx_ready1, frame_done1}, exp_vec(d, c, 1));
        end
      end
    end
  endtask

  initial begin
    tx_valid = 1'b0; tx_data = 8'h00; tx_valid1 = 1'b0; tx_data1 = 8'h00; rst = 1'b0;
    test_reset;
    test_frames;
    test_back_to_back;
    test_busy_ignore;
    test_reset_mid_frame;
    test_bit_cycles_1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
